// File: rtl/ov7670_pixel_capture_if.sv
// Camera-side bus of the OV7670 capture stage.
// The slave modport is the capture block; the master is its environment.
interface ov7670_pixel_capture_if;
  logic        capture_en;
  logic        vref;
  logic        href;
  logic [7:0]  d;
  logic [11:0] rgb;
  logic        pix_valid;
  logic        sol;
  logic        eol;
  logic        sof;
  logic        eof;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        line_err;
  logic [7:0]  frame_cnt;
  logic        busy;

  modport master (
    output capture_en, vref, href, d,
    input  rgb, pix_valid, sol, eol, sof, eof,
    input  x, y, line_err, frame_cnt, busy
  );

  modport slave (
    input  capture_en, vref, href, d,
    output rgb, pix_valid, sol, eol, sof, eof,
    output x, y, line_err, frame_cnt, busy
  );
endinterface

// File: rtl/ov7670_pixel_capture.sv
// OV7670 byte-stream framer: pairs bytes into RGB444 pixels and
// emits registered pixel/line/frame strobes in the pclk domain.
module ov7670_pixel_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter bit FMT_565  = 1'b0
) (
  input logic               clk,
  input logic               rst_n,
  ov7670_pixel_capture_if.slave bus
);

  localparam logic [9:0] H_LIM = 10'(H_PIXELS);
  localparam logic [8:0] V_LIM = 9'(V_LINES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        phase_q, phase_d;
  logic [7:0]  b0_q, b0_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic        in_line_q, in_line_d;
  logic [8:0]  y_q, y_d;
  logic [9:0]  x_q, x_d;
  logic [11:0] rgb_q, rgb_d;
  logic        pix_q, pix_d;
  logic        sol_q, sol_d;
  logic        eol_q, eol_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic        busy_q, busy_d;

  logic [11:0] pix_rgb;
  logic        line_live;
  logic        line_bad;

  // RGB565 keeps the top 4 bits of each field
  assign pix_rgb = FMT_565
    ? {b0_q[7:4], b0_q[2:0], bus.d[7], bus.d[4:1]}
    : {b0_q[3:0], bus.d};

  assign line_live = (y_q < V_LIM);
  assign line_bad  = (cnt_q != H_LIM) || ovf_q || phase_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    b0_d      = b0_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    in_line_d = in_line_q;
    y_d       = y_q;
    x_d       = x_q;
    rgb_d     = rgb_q;
    pix_d     = 1'b0;
    sol_d     = 1'b0;
    eol_d     = 1'b0;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    err_d     = 1'b0;
    fcnt_d    = fcnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.capture_en && bus.vref) begin
          state_d = ARMED;
        end
      end

      ARMED: begin
        if (!bus.vref) begin
          state_d   = FRAME;
          sof_d     = 1'b1;
          x_d       = '0;
          y_d       = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          phase_d   = 1'b0;
          in_line_d = 1'b0;
        end
      end

      FRAME: begin
        if (bus.vref) begin
          // vref wins: a line still running is closed as truncated
          eof_d   = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          state_d = bus.capture_en ? ARMED : IDLE;
          if ((bus.href || in_line_q) && line_live) begin
            eol_d = 1'b1;
            err_d = bus.href || line_bad;
          end
          phase_d   = 1'b0;
          in_line_d = 1'b0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          x_d       = '0;
        end else if (bus.href) begin
          in_line_d = 1'b1;
          if (!phase_q) begin
            b0_d    = bus.d;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (cnt_q < H_LIM) begin
              cnt_d = cnt_q + 10'd1;
              x_d   = cnt_q;
              if (line_live) begin
                pix_d = 1'b1;
                sol_d = (cnt_q == '0);
                rgb_d = pix_rgb;
              end
            end else begin
              ovf_d = 1'b1;
              x_d   = H_LIM;
            end
          end
        end else if (in_line_q) begin
          eol_d     = line_live;
          err_d     = line_live && line_bad;
          y_d       = line_live ? y_q + 9'd1 : y_q;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          x_d       = '0;
          phase_d   = 1'b0;
          in_line_d = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == FRAME);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      phase_q   <= 1'b0;
      b0_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      in_line_q <= 1'b0;
      y_q       <= '0;
      x_q       <= '0;
      rgb_q     <= '0;
      pix_q     <= 1'b0;
      sol_q     <= 1'b0;
      eol_q     <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      b0_q      <= b0_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      in_line_q <= in_line_d;
      y_q       <= y_d;
      x_q       <= x_d;
      rgb_q     <= rgb_d;
      pix_q     <= pix_d;
      sol_q     <= sol_d;
      eol_q     <= eol_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.pix_valid = pix_q;
  assign bus.sol       = sol_q;
  assign bus.eol       = eol_q;
  assign bus.sof       = sof_q;
  assign bus.eof       = eof_q;
  assign bus.x         = x_q;
  assign bus.y         = y_q;
  assign bus.line_err  = err_q;
  assign bus.frame_cnt = fcnt_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture: table vectors, hand sequences and
// random frames scored against a line-level reference model.
module tb_ov7670_pixel_capture;

  localparam int H = 8;
  localparam int V = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ov7670_pixel_capture_if if0 ();
  ov7670_pixel_capture_if if1 ();

  assign if1.capture_en = if0.capture_en;
  assign if1.vref       = if0.vref;
  assign if1.href       = if0.href;
  assign if1.d          = if0.d;

  ov7670_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .FMT_565(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(if0)
  );
  ov7670_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .FMT_565(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );

  typedef struct packed {
    logic [11:0] r0;
    logic [11:0] r1;
    logic [9:0]  x;
    logic [8:0]  y;
    logic        sol;
    logic        pv1;
  } pix_t;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [11:0] e444;
    logic [11:0] e565;
  } vec_t;

  typedef enum {M_IDLE, M_ARMED, M_FRAME} mmode_e;

  int vectors = 0;
  int miscompares = 0;

  pix_t exp_pix[$];
  pix_t got_pix[$];
  bit   exp_eol[$];
  bit   got_eol[$];
  int   exp_sof, exp_eof, got_sof, got_eof, got_lerr;
  logic [7:0] exp_fc;
  mmode_e m_mode;
  int   line_no;
  logic [9:0] x_before_eol;

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (if0.pix_valid) begin
        pix_t p;
        p.r0  = if0.rgb;
        p.r1  = if1.rgb;
        p.x   = if0.x;
        p.y   = if0.y;
        p.sol = if0.sol;
        p.pv1 = if1.pix_valid;
        got_pix.push_back(p);
      end
      if (if0.eol) got_eol.push_back(if0.line_err);
      if (if0.line_err) got_lerr++;
      if (if0.sof) got_sof++;
      if (if0.eof) got_eof++;
    end
  end

  task automatic clear_all();
    exp_pix.delete();
    got_pix.delete();
    exp_eol.delete();
    got_eol.delete();
    exp_sof = 0;
    exp_eof = 0;
    got_sof = 0;
    got_eof = 0;
    got_lerr = 0;
  endtask

  // frame-level transitions, evaluated on the values the next edge samples
  task automatic tick();
    if (m_mode == M_FRAME && if0.vref) begin
      exp_eof++;
      exp_fc = exp_fc + 8'd1;
      m_mode = if0.capture_en ? M_ARMED : M_IDLE;
    end else if (m_mode == M_IDLE && if0.capture_en && if0.vref) begin
      m_mode = M_ARMED;
    end else if (m_mode == M_ARMED && !if0.vref) begin
      m_mode = M_FRAME;
      exp_sof++;
      line_no = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic line_model(input logic [7:0] bq[$], input bit trunc);
    int np;
    pix_t p;
    logic [7:0] a, b;
    if (m_mode != M_FRAME) return;
    if (line_no < V) begin
      np = bq.size() / 2;
      for (int k = 0; k < np && k < H; k++) begin
        a = bq[2*k];
        b = bq[2*k+1];
        p.r0  = {a[3:0], b};
        p.r1  = {a[7:4], a[2:0], b[7], b[4:1]};
        p.x   = 10'(k);
        p.y   = 9'(line_no);
        p.sol = (k == 0);
        p.pv1 = 1'b1;
        exp_pix.push_back(p);
      end
      exp_eol.push_back(trunc || np != H || (bq.size() % 2) != 0);
    end
    line_no++;
  endtask

  task automatic mk_line(input int n, output logic [7:0] bq[$]);
    bq = {};
    repeat (n) bq.push_back(8'($urandom));
  endtask

  task automatic drive_line(input logic [7:0] bq[$], input bit trunc,
                            input int gap);
    if0.href = 1'b1;
    foreach (bq[i]) begin
      if0.d = bq[i];
      tick();
    end
    x_before_eol = if0.x;
    line_model(bq, trunc);
    if (trunc) begin
      if0.vref = 1'b1;
      if0.d = 8'h00;
      tick();
    end
    if0.href = 1'b0;
    if0.d = 8'h00;
    repeat (gap) tick();
  endtask

  task automatic vblank(input int n);
    if0.vref = 1'b1;
    repeat (n) tick();
  endtask

  task automatic vstart();
    bit will;
    will = (m_mode == M_ARMED);
    if0.vref = 1'b0;
    tick();
    chk("sof_at_start", if0.sof, will);
    chk("busy_at_start", if0.busy, will);
  endtask

  task automatic rand_frame(input int nlines, input int drop_at);
    logic [7:0] bq[$];
    int n;
    vblank(2 + $urandom_range(0, 2));
    vstart();
    for (int l = 0; l < nlines; l++) begin
      if (l == drop_at) if0.capture_en = 1'b0;
      case ($urandom_range(0, 5))
        0, 1, 2: n = 2 * H;
        3:       n = 2 * H - 1;
        4:       n = 2 * H + 2;
        default: n = $urandom_range(2, 2 * H + 4);
      endcase
      mk_line(n, bq);
      drive_line(bq, 1'b0, 1 + $urandom_range(0, 3));
    end
    vblank(1);
  endtask

  task automatic check_frame(input string nm);
    int ne;
    repeat (2) tick();
    chk({nm, "_npix"}, got_pix.size(), exp_pix.size());
    for (int i = 0; i < exp_pix.size() && i < got_pix.size(); i++)
      chk({nm, "_pix"}, got_pix[i], exp_pix[i]);
    chk({nm, "_neol"}, got_eol.size(), exp_eol.size());
    for (int i = 0; i < exp_eol.size() && i < got_eol.size(); i++)
      chk({nm, "_eol_err"}, got_eol[i], exp_eol[i]);
    ne = 0;
    foreach (exp_eol[i]) ne += int'(exp_eol[i]);
    chk({nm, "_nlerr"}, got_lerr, ne);
    chk({nm, "_nsof"}, got_sof, exp_sof);
    chk({nm, "_neof"}, got_eof, exp_eof);
    chk({nm, "_fcnt"}, if0.frame_cnt, exp_fc);
    clear_all();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_rgb"}, {if0.rgb, if1.rgb}, 0);
    chk({nm, "_strb"}, {if0.pix_valid, if0.sol, if0.eol, if0.sof,
                        if0.eof, if0.line_err, if0.busy,
                        if1.pix_valid, if1.eof, if1.busy}, 0);
    chk({nm, "_xy"}, {if0.x, if0.y}, 0);
    chk({nm, "_fcnt"}, {if0.frame_cnt, if1.frame_cnt}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt[8];
    logic [7:0] bq[$];

    vt[0] = '{8'h0A, 8'h5C, 12'hA5C, 12'h04E};
    vt[1] = '{8'hF8, 8'h1F, 12'h81F, 12'hF0F};
    vt[2] = '{8'hFF, 8'hFF, 12'hFFF, 12'hFFF};
    vt[3] = '{8'h00, 8'h00, 12'h000, 12'h000};
    vt[4] = '{8'h35, 8'hA7, 12'h5A7, 12'h3B3};
    vt[5] = '{8'hC2, 8'h6E, 12'h26E, 12'hC47};
    vt[6] = '{8'h12, 8'h34, 12'h234, 12'h14A};
    vt[7] = '{8'h80, 8'h01, 12'h001, 12'h800};

    if0.capture_en = 1'b0;
    if0.vref = 1'b0;
    if0.href = 1'b0;
    if0.d = 8'h00;
    m_mode = M_IDLE;
    exp_fc = 8'd0;
    line_no = 0;
    clear_all();

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    // capture disarmed: a whole frame passes with no output
    rand_frame(V, -1);
    check_frame("idle");

    // table-driven first line, then length corner cases
    if0.capture_en = 1'b1;
    vblank(3);
    vstart();
    if0.href = 1'b1;
    bq = {};
    for (int i = 0; i < H; i++) begin
      if0.d = vt[i].b0;
      bq.push_back(vt[i].b0);
      tick();
      if (i == 0) chk("lat_b0_no_pix", if0.pix_valid, 0);
      if0.d = vt[i].b1;
      bq.push_back(vt[i].b1);
      tick();
      if (i == 0) begin
        chk("lat_pix_valid", if0.pix_valid, 1);
        chk("lat_rgb444", if0.rgb, vt[0].e444);
        chk("lat_rgb565", if1.rgb, vt[0].e565);
        chk("lat_sol", if0.sol, 1);
      end
    end
    line_model(bq, 1'b0);
    if0.href = 1'b0;
    tick();
    chk("tbl_eol", {if0.eol, if0.line_err}, 2'b10);
    tick();
    mk_line(2 * H, bq);
    drive_line(bq, 1'b0, 2);
    mk_line(2 * H + 3, bq);
    drive_line(bq, 1'b0, 2);
    chk("x_saturate", x_before_eol, 10'(H));
    mk_line(2 * H, bq);
    drive_line(bq, 1'b0, 2);
    mk_line(2 * H - 2, bq);
    drive_line(bq, 1'b0, 2);
    mk_line(2 * H, bq);
    drive_line(bq, 1'b0, 2);
    mk_line(2 * H, bq);
    drive_line(bq, 1'b0, 2);
    vblank(1);
    chk("tbl_npix", got_pix.size() >= H, 1);
    for (int i = 0; i < H && i < got_pix.size(); i++) begin
      chk("tbl_rgb444", got_pix[i].r0, vt[i].e444);
      chk("tbl_rgb565", got_pix[i].r1, vt[i].e565);
      chk("tbl_x", got_pix[i].x, 10'(i));
    end
    check_frame("table");

    // random frames, one extra line to exercise vertical clipping
    for (int f = 0; f < 4; f++) begin
      rand_frame(V + 1, -1);
      check_frame("rand");
    end

    // vref rises mid-line
    vblank(2);
    vstart();
    mk_line(2 * H, bq);
    drive_line(bq, 1'b0, 2);
    if0.href = 1'b1;
    mk_line(10, bq);
    foreach (bq[i]) begin
      if0.d = bq[i];
      tick();
    end
    line_model(bq, 1'b1);
    if0.vref = 1'b1;
    tick();
    chk("trunc_eol_err_eof", {if0.eol, if0.line_err, if0.eof}, 3'b111);
    chk("trunc_busy", if0.busy, 0);
    if0.href = 1'b0;
    tick();
    check_frame("trunc");
    // left ARMED: starts even though capture_en is now low
    if0.capture_en = 1'b0;
    rand_frame(V, -1);
    check_frame("after_trunc");
    chk("after_trunc_busy", if0.busy, 0);

    // capture_en dropped mid-frame, then an ignored frame
    if0.capture_en = 1'b1;
    rand_frame(V, 3);
    check_frame("drop_en");
    chk("drop_en_busy", if0.busy, 0);
    rand_frame(V, -1);
    check_frame("drop_en_ignored");

    // reset in the middle of a line
    if0.capture_en = 1'b1;
    vblank(3);
    vstart();
    for (int l = 0; l < 2; l++) begin
      mk_line(2 * H, bq);
      drive_line(bq, 1'b0, 2);
    end
    if0.href = 1'b1;
    repeat (5) begin
      if0.d = 8'($urandom);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    m_mode = M_IDLE;
    exp_fc = 8'd0;
    clear_all();
    tick();
    rst_n = 1'b1;
    repeat (6) begin
      if0.d = 8'($urandom);
      tick();
    end
    if0.href = 1'b0;
    tick();
    for (int l = 0; l < 2; l++) begin
      mk_line(2 * H, bq);
      drive_line(bq, 1'b0, 2);
    end
    check_frame("post_rst");
    rand_frame(V, -1);
    check_frame("resume");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
